dmem_responder: RTL and testbench

//  Data-memory responder: the target end of the core's load/store request interface.

---
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_responder.sv | 112 +++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store request and response channels between LSU and data memory.
// master = requester (core LSU), slave = responder (memory).
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed latency, byte-masked stores.
// Define DMEM_ERR_EN to flag out-of-range addresses instead of aliasing them.
module dmem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input logic  clk,
  input logic  reset,
  dmem_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        err;
  logic        accept;
  logic        access;
  logic        hit;
  logic [31:0] off;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  // Offset in 32-bit unsigned arithmetic, so addresses below BASE wrap high.
  assign off = addr - BASE;
  assign idx = off[AW+1:2];

`ifdef DMEM_ERR_EN
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  assign hit = (off < SPAN);
`else
  logic unused_off;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  assign hit = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.req_valid)  state_nx = WAIT;
      WAIT: if (cnt == '0)      state_nx = RESP;
      RESP: if (bus.rsp_ready)  state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    accept        = (state == IDLE) && bus.req_valid;
    access        = (state == WAIT) && (cnt == '0);
  end

  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      wen   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      wmask <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= CNT_INIT;
        wen   <= bus.req_wen;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
        wmask <= bus.req_wmask;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err   <= !hit;
        rdata <= (!wen && hit) ? mem[idx] : '0;
      end
    end
  end

  // Storage has no reset; gating on reset keeps an aborted store out.
  always_ff @(posedge clk) begin
    if (reset && access && wen && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses,
// a negedge monitor pops and compares on each completed response.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_responder #(
    .BASE(BASE),
    .DEPTH(1024),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ncnt = 0;
  int   acc_n = 0;
  int   next_id = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: latency of each response, then scoreboard compare on handshake.
  always @(negedge clk) begin
    ncnt++;
    if (bus.req_valid && bus.req_ready) acc_n = ncnt;
    if (reset && bus.rsp_valid && !prev_valid)
      chk("latency", 32'(ncnt - acc_n), 32'(LAT + 1));
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h want none",
                 bus.rsp_rdata);
      end else begin
        mon_e = q.pop_front();
        chk($sformatf("rsp%0d_rdata", mon_e.id), bus.rsp_rdata, mon_e.rdata);
        chk($sformatf("rsp%0d_err", mon_e.id), {31'b0, bus.rsp_err},
            {31'b0, mon_e.err});
      end
    end
    prev_valid = bus.rsp_valid;
  end

  task automatic req(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     input logic [31:0] er, input logic ee);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_wen   = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) q.push_back('{rdata: er, err: ee, id: next_id});
    else chk("accept_timeout", 32'd0, 32'd1);
    next_id++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !bus.rsp_valid) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  // Caller positions this just after a rising edge.
  task automatic pulse_reset(input string nm);
    reset = 1'b0;
    #1;
    chk({nm, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({nm, "_rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
    chk({nm, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk({nm, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);

    // Full-word store then load.
    req(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    drain();

    // Byte-lane merge, ignored low address bits, empty mask.
    req(1, 32'h8000_0010, 32'h0000_00AA, 4'b0001, 32'h0, 0);
    req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0);
    req(0, 32'h8000_0013, 32'h0, 4'h0, 32'hDEAD_BEAA, 0);
    req(1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 0);
    req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0);
    drain();

    @(posedge clk); #1;
    pulse_reset("t1");

    // Back-pressure on the response channel.
    bus.rsp_ready = 1'b0;
    req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_valid_seen", {31'b0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("t4_hold_rdata", bus.rsp_rdata, 32'hDEAD_BEAA);
      chk("t4_hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("t4_idle_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    drain();

    // Range boundaries and out-of-range behaviour.
    req(1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0, 0);
    req(1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
    req(0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
    req(0, 32'h8000_0000, 32'h0, 4'h0, 32'h1234_5678, 0);
`ifdef DMEM_ERR_EN
    req(0, 32'h9000_0000, 32'h0, 4'h0, 32'h0, 1);
    req(0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1);
    req(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1);
`else
    req(0, 32'h9000_0000, 32'h0, 4'h0, 32'h1234_5678, 0);
    req(0, 32'h8000_1000, 32'h0, 4'h0, 32'h1234_5678, 0);
    req(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
`endif
    drain();

    // Reset mid-WAIT must abort the store.
    req(1, 32'h8000_0010, 32'h1111_1111, 4'hF, 32'h0, 0);
    @(posedge clk); #1;
    pulse_reset("t6");
    req(0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEAA, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
